rc5_key_mixer: RTL and testbench

RC5 key-schedule mixing stage for RC5-32/12/16, directly downstream of `keyBytesToWords`. Once the upstream stage asserts `done`, this block copies the finished L words from the upstream L memory and fills S with the magic-constant progression. It then runs the 3·max(t,c) mixing iterations and exposes the expanded table S through a combinational read port for the encrypt/decrypt datapath.

---
 rtl/rc5_pkg.sv | 49 ++++
 rtl/rc5_rotl.sv | 29 ++
 rtl/rc5_key_mixer.sv | 215 +++++++++++++++++++++
 tb/tb_rc5_key_mixer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc5_pkg.sv
// -----------------------------------------------------------------------------
// rc5_pkg
//
// Shared constants and types for the RC5-32/12/16 key-schedule mixing stage.
//
// Contents:
//   w, u, b, r, t, c            word size, bytes/word, key bytes, rounds, S size, L size
//   t_length, c_length, lg_w    address widths and rotate-amount width
//   P_w, Q_w                    magic constants
//   state_t                     key-mixer FSM states
//   mix_iterations()            n = 3 * max(t, c)
//   init_word(k)                P_w + k*Q_w, used to elaborate the S table
//                               constants when RC5_KEY_MIXER_INIT_PARALLEL_EN
//                               is defined
// -----------------------------------------------------------------------------
package rc5_pkg;

    localparam int w        = 32;          // bits per word
    localparam int u        = w / 8;       // bytes per word
    localparam int b        = 16;          // key bytes
    localparam int r        = 12;          // rounds
    localparam int t        = 2 * (r + 1); // S table size (26)
    localparam int c        = b / u;       // L table size (4)
    localparam int t_length = 5;           // S address bits
    localparam int c_length = 2;           // L address bits
    localparam int lg_w     = $clog2(w);   // rotate-amount bits

    localparam logic [w-1:0] P_w = 32'hB7E15163;
    localparam logic [w-1:0] Q_w = 32'h9E3779B9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_L = 3'd1,
        INIT_S = 3'd2,
        MIX    = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Number of mixing iterations: 3 * max(t, c).
    function automatic int mix_iterations();
        return 3 * ((t > c) ? t : c);
    endfunction

    // Initial S entry k, P + k*Q mod 2^w. Only evaluated on constants.
    function automatic logic [w-1:0] init_word(input int k);
        return P_w + (w'(k) * Q_w);
    endfunction

endpackage

// File: rtl/rc5_rotl.sv
// -----------------------------------------------------------------------------
// rc5_rotl
//
// W-bit barrel rotate-left by an AW-bit amount. Purely combinational.
//
// Ports:
//   x    in   W   value to rotate
//   amt  in   AW  rotate amount (0 .. W-1)
//   y    out  W   x rotated left by amt
// -----------------------------------------------------------------------------
module rc5_rotl #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic [W-1:0]  x,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  y
);

    // Shift a doubled copy left; the upper half is then the rotated word,
    // which handles amt = 0 without a special case.
    logic [2*W-1:0] doubled;

    always_comb begin
        doubled = {x, x} << amt;
        y       = doubled[2*W-1:W];
    end

endmodule

// File: rtl/rc5_key_mixer.sv
// -----------------------------------------------------------------------------
// rc5_key_mixer
//
// RC5-32/12/16 key-schedule mixing stage. On an accepted start it copies the
// c L words from the upstream L memory, fills S with P + k*Q, runs
// n = 3*max(t,c) mixing iterations and then holds the expanded table S,
// readable through a combinational port.
//
// Configuration macro:
//   RC5_KEY_MIXER_INIT_PARALLEL_EN  defined   : INIT_S is a single cycle that
//                                                writes all t entries from
//                                                elaborated constants
//                                                (done at T84).
//                                   undefined : INIT_S runs t cycles with a
//                                                running accumulator (done at
//                                                T109).
//
// Ports:
//   clk1       in   1         clock, all state on its rising edge
//   rst        in   1         asynchronous active-low reset
//   start      in   1         one-cycle start pulse, accepted in IDLE or DONE
//   L_address  out  c_length  read address into the upstream L memory
//   L_sub_i    in   w         L word at L_address, valid in the same cycle
//   S_address  in   t_length  S read address
//   S_sub_i    out  w         S[S_address], 0 for addresses t..2^t_length-1
//   busy       out  1         high from the cycle after start until done rises
//   done       out  1         S final; held until the next accepted start
//
// Handshake: start is a single-cycle request with no ready; it is acted on
// only in IDLE or DONE and silently dropped in any other state. done is a
// level that stays high until the next accepted start.
// -----------------------------------------------------------------------------
module rc5_key_mixer
    import rc5_pkg::*;
(
    input  logic                clk1,
    input  logic                rst,
    input  logic                start,
    output logic [c_length-1:0] L_address,
    input  logic [w-1:0]        L_sub_i,
    input  logic [t_length-1:0] S_address,
    output logic [w-1:0]        S_sub_i,
    output logic                busy,
    output logic                done
);

    localparam int n         = mix_iterations();
    localparam int iter_bits = $clog2(n);

    localparam logic [t_length-1:0]  T_SIZE = t_length'(t);
    localparam logic [t_length-1:0]  T_LAST = t_length'(t - 1);
    localparam logic [c_length-1:0]  C_LAST = c_length'(c - 1);
    localparam logic [iter_bits-1:0] N_LAST = iter_bits'(n - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state;
    logic [w-1:0]         s_mem [t];
    logic [w-1:0]         lr    [c];
    logic [w-1:0]         a;
    logic [w-1:0]         b;
    logic [t_length-1:0]  i_idx;      // S index in MIX, fill index in INIT_S
    logic [c_length-1:0]  j_idx;      // L index in MIX
    logic [iter_bits-1:0] iter;       // MIX iteration counter
`ifndef RC5_KEY_MIXER_INIT_PARALLEL_EN
    logic [w-1:0]         acc;        // running P + k*Q
`endif

    // ------------------------------------------------------------------
    // Mixing datapath: one iteration per cycle.
    //   A' = rotl(S[i] + A + B, 3)
    //   B' = rotl(L[j] + A' + B, (A' + B)[lg_w-1:0])
    // ------------------------------------------------------------------
    logic [w-1:0] a_sum;
    logic [w-1:0] a_next;
    logic [w-1:0] ab_sum;
    logic [w-1:0] b_sum;
    logic [w-1:0] b_next;

    always_comb begin
        a_sum  = s_mem[i_idx] + a + b;
        ab_sum = a_next + b;
        b_sum  = lr[j_idx] + ab_sum;
    end

    rc5_rotl #(.W(w), .AW(lg_w)) u_rotl_a (
        .x   (a_sum),
        .amt (lg_w'(3)),
        .y   (a_next)
    );

    rc5_rotl #(.W(w), .AW(lg_w)) u_rotl_b (
        .x   (b_sum),
        .amt (ab_sum[lg_w-1:0]),
        .y   (b_next)
    );

    // Wrapping increments; compare-and-clear instead of a modulo.
    logic [t_length-1:0] i_inc;
    logic [c_length-1:0] j_inc;

    always_comb begin
        i_inc = (i_idx == T_LAST) ? '0 : i_idx + 1'b1;
        j_inc = (j_idx == C_LAST) ? '0 : j_idx + 1'b1;
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    always_comb begin
        S_sub_i = '0;
        if (S_address < T_SIZE) begin
            S_sub_i = s_mem[S_address];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and table updates
    // ------------------------------------------------------------------
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            L_address <= '0;
            a         <= '0;
            b         <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            iter      <= '0;
`ifndef RC5_KEY_MIXER_INIT_PARALLEL_EN
            acc       <= '0;
`endif
            for (int k = 0; k < t; k++) begin
                s_mem[k] <= '0;
            end
            for (int k = 0; k < c; k++) begin
                lr[k] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD_L;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        L_address <= '0;
                        a         <= '0;
                        b         <= '0;
                        i_idx     <= '0;
                        j_idx     <= '0;
                        iter      <= '0;
`ifndef RC5_KEY_MIXER_INIT_PARALLEL_EN
                        acc       <= P_w;
`endif
                    end
                end

                // L_address doubles as the copy counter; it returns to 0
                // on the last word so it reads 0 outside this state.
                LOAD_L: begin
                    lr[L_address] <= L_sub_i;
                    if (L_address == C_LAST) begin
                        L_address <= '0;
                        state     <= INIT_S;
                    end else begin
                        L_address <= L_address + 1'b1;
                    end
                end

                INIT_S: begin
`ifdef RC5_KEY_MIXER_INIT_PARALLEL_EN
                    for (int k = 0; k < t; k++) begin
                        s_mem[k] <= init_word(k);
                    end
                    state <= MIX;
`else
                    s_mem[i_idx] <= acc;
                    acc          <= acc + Q_w;
                    if (i_idx == T_LAST) begin
                        i_idx <= '0;
                        state <= MIX;
                    end else begin
                        i_idx <= i_idx + 1'b1;
                    end
`endif
                end

                MIX: begin
                    s_mem[i_idx] <= a_next;
                    lr[j_idx]    <= b_next;
                    a            <= a_next;
                    b            <= b_next;
                    i_idx        <= i_inc;
                    j_idx        <= j_inc;
                    if (iter == N_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_mixer.sv
`timescale 1ns/100ps
module tb_rc5_key_mixer;

    localparam logic [31:0] P_W = 32'hB7E15163;
    localparam logic [31:0] Q_W = 32'h9E3779B9;
`ifdef RC5_KEY_MIXER_INIT_PARALLEL_EN
    localparam int LAT = 84;
`else
    localparam int LAT = 109;
`endif
    localparam int MIX_T0 = LAT - 78;   // first MIX cycle

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk1 = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  L_address;
    logic [31:0] L_sub_i;
    logic [4:0]  S_address;
    logic [31:0] S_sub_i;
    logic        busy;
    logic        done;

    always #5 clk1 = ~clk1;

    rc5_key_mixer dut (
        .clk1      (clk1),
        .rst       (rst),
        .start     (start),
        .L_address (L_address),
        .L_sub_i   (L_sub_i),
        .S_address (S_address),
        .S_sub_i   (S_sub_i),
        .busy      (busy),
        .done      (done)
    );

    // Upstream L memory, combinational read.
    logic [31:0] lmem [4];
    assign L_sub_i = lmem[L_address];

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q [$];
    int cyc = 0;
    int t0  = 0;
    int t_cnt = -1;       // cycle index within the current run, -1 = idle
    bit chk_en = 1'b0;

    always @(posedge clk1) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int sh);
        int s;
        s = sh % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    // Full key schedule from four L words; pushes S[0..25] onto exp_q.
    task automatic model_compute(input logic [31:0] l0, input logic [31:0] l1,
                                 input logic [31:0] l2, input logic [31:0] l3);
        logic [31:0] s [26];
        logic [31:0] l [4];
        logic [31:0] a, b;
        int i, j;
        l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
        for (int k = 0; k < 26; k++) s[k] = P_W + 32'(k) * Q_W;
        a = 0; b = 0; i = 0; j = 0;
        for (int it = 0; it < 78; it++) begin
            a = rotl(s[i] + a + b, 3);
            s[i] = a;
            b = rotl(l[j] + a + b, int'((a + b) & 32'd31));
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
        for (int k = 0; k < 26; k++) exp_q.push_back(s[k]);
    endtask

    // Cycle-position model of the control outputs.
    always @(posedge clk1 or negedge rst) begin
        if (!rst) t_cnt = -1;
        else if (start && (t_cnt < 0 || t_cnt >= LAT)) t_cnt = 1;
        else if (t_cnt >= 1 && t_cnt < LAT) t_cnt++;
    end

    // Compare process: control outputs every cycle.
    always @(negedge clk1) begin
        logic exp_busy, exp_done;
        logic [1:0] exp_la;
        if (chk_en) begin
            exp_busy = 1'b0; exp_done = 1'b0; exp_la = 2'd0;
            if (rst && t_cnt >= 1) begin
                exp_busy = (t_cnt < LAT);
                exp_done = (t_cnt >= LAT);
                if (t_cnt <= 4) exp_la = 2'(t_cnt - 1);
            end
            check($sformatf("busy@t%0d", t_cnt), 32'(busy), 32'(exp_busy));
            check($sformatf("done@t%0d", t_cnt), 32'(done), 32'(exp_done));
            check($sformatf("L_address@t%0d", t_cnt), 32'(L_address), 32'(exp_la));
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk1);
        #2;
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b0;
        repeat (ncyc) step();
        rst = 1'b1;
    endtask

    // Drives start for the current cycle (T0); returns in T1.
    task automatic pulse_start();
        t0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_l(input logic [31:0] l0, input logic [31:0] l1,
                         input logic [31:0] l2, input logic [31:0] l3);
        lmem[0] = l0; lmem[1] = l1; lmem[2] = l2; lmem[3] = l3;
    endtask

    task automatic set_l_random_and_model();
        set_l($urandom, $urandom, $urandom, $urandom);
        model_compute(lmem[0], lmem[1], lmem[2], lmem[3]);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 300) begin
            step();
            k++;
        end
        if (!done) check({name, "_done_timeout"}, 32'd0, 32'd1);
        else check({name, "_latency"}, 32'(cyc - t0), 32'(LAT));
    endtask

    // Compares all 26 S words against exp_q inside a single cycle.
    task automatic scan_s(input string name);
        for (int a = 0; a < 26; a++) begin
            S_address = 5'(a);
            #0.2;
            if (exp_q.size() == 0) check({name, "_exp_q_empty"}, 32'd0, 32'd1);
            else check($sformatf("%s_S[%0d]", name, a), S_sub_i, exp_q.pop_front());
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b0;
        start = 1'b0;
        S_address = '0;
        set_l(0, 0, 0, 0);

        // Reset then idle
        do_reset(3);
        chk_en = 1'b1;
        step();
        for (int a = 0; a < 32; a++) begin
            S_address = 5'(a);
            #0.2;
            check($sformatf("reset_S[%0d]", a), S_sub_i, 32'd0);
        end

        // Model pins against hand-computed values
        check("model_init_S1", P_W + 32'd1 * Q_W, 32'h5618CB1C);
        check("model_mix0_S0", rotl(P_W, 3), 32'hBF0A8B1D);

        // All-zero L with INIT_S / first-iteration probes
        set_l(0, 0, 0, 0);
        model_compute(0, 0, 0, 0);
        step();
        pulse_start();
        repeat (MIX_T0 - 1) step();
        S_address = 5'd1;
        #1 check("probe_init_S1", S_sub_i, 32'h5618CB1C);
        step();
        S_address = 5'd0;
        #1 check("probe_mix0_S0", S_sub_i, 32'hBF0A8B1D);
        wait_done("zero_key");
        scan_s("zero_key");
        for (int a = 26; a < 32; a++) begin
            S_address = 5'(a);
            #0.2;
            check($sformatf("oob_S[%0d]", a), S_sub_i, 32'd0);
        end

        // Upstream key FFFEEEE58684FFF05FFE493853000434, little-endian words
        step();
        set_l(32'hE5EEFEFF, 32'hF0FF8486, 32'h3849FE5F, 32'h34040053);
        model_compute(lmem[0], lmem[1], lmem[2], lmem[3]);
        pulse_start();
        wait_done("key");
        scan_s("key");

        // start during MIX at T40 is ignored
        step();
        set_l_random_and_model();
        pulse_start();
        repeat (39) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ignored_start");
        scan_s("ignored_start");

        // Reset at T60, then a fresh run
        step();
        set_l($urandom, $urandom, $urandom, $urandom);
        pulse_start();
        repeat (59) step();
        rst = 1'b0;
        S_address = 5'd0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_S0", S_sub_i, 32'd0);
        check("midrst_L_address", 32'(L_address), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        set_l_random_and_model();
        pulse_start();
        wait_done("after_reset");
        scan_s("after_reset");

        // Back-to-back: restart in the first done cycle with a new L
        for (int rep = 0; rep < 3; rep++) begin
            step();
            set_l_random_and_model();
            pulse_start();
            wait_done("b2b_first");
            scan_s("b2b_first");
            set_l_random_and_model();
            pulse_start();
            check("b2b_done_drop", 32'(done), 32'd0);
            wait_done("b2b_second");
            scan_s("b2b_second");
        end

        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
